// File: rtl/gf2_mat_pkg.sv
// Shared types and constants for the serial-load GF(2) 2x2 matrix-vector iterator.
package gf2_mat_pkg;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_COMP = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  localparam int unsigned MAT_BITS  = 6;
  localparam int unsigned BIT_CNT_W = 3;

  // Storage index of each load beat; beat order is a,b,c,d,e,f.
  localparam int unsigned IDX_A = 0;
  localparam int unsigned IDX_B = 1;
  localparam int unsigned IDX_C = 2;
  localparam int unsigned IDX_D = 3;
  localparam int unsigned IDX_E = 4;
  localparam int unsigned IDX_F = 5;

  // One GF(2) row-by-column product: AND multiplies, XOR adds.
  function automatic logic gf2_dot(input logic x0, input logic y0,
                                   input logic x1, input logic y1);
    return (x0 & y0) ^ (x1 & y1);
  endfunction

endpackage

// File: rtl/matrix_vec_mul.sv
// Combinational 2x2 GF(2) matrix times 2-vector: [g;h] = [a b; c d] * [e;f].
module matrix_vec_mul
  import gf2_mat_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  input  logic f,
  output logic g,
  output logic h
);

  // Each output row is an independent dot product over GF(2).
  always_comb begin
    g = gf2_dot(a, e, b, f);
    h = gf2_dot(c, e, d, f);
  end

endmodule

// File: rtl/gf2_mat_vec_iter.sv
// Serially loads M and v, applies v <- M*v ITERS times, then presents v on a
// valid/ready port. Load, compute and output phases never overlap.
module gf2_mat_vec_iter
  import gf2_mat_pkg::*;
#(
  parameter int unsigned ITERS = 1,
  parameter int unsigned CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic out_g,
  output logic out_h,
  output logic busy
);

  localparam logic [CNT_W-1:0]     ITER_LAST = CNT_W'(ITERS - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(MAT_BITS - 1);

  state_e               state_q,     state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
  logic [CNT_W-1:0]     iter_cnt_q,  iter_cnt_d;
  logic [MAT_BITS-1:0]  regs_q,      regs_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_g_q,     out_g_d;
  logic                 out_h_q,     out_h_d;
  logic                 in_ready_q,  in_ready_d;
  logic                 busy_q,      busy_d;

  logic mv_g;
  logic mv_h;
  logic beat;

  matrix_vec_mul u_mvm (
    .a (regs_q[IDX_A]),
    .b (regs_q[IDX_B]),
    .c (regs_q[IDX_C]),
    .d (regs_q[IDX_D]),
    .e (regs_q[IDX_E]),
    .f (regs_q[IDX_F]),
    .g (mv_g),
    .h (mv_h)
  );

  assign beat = in_valid & in_ready_q;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    iter_cnt_d  = iter_cnt_q;
    regs_d      = regs_q;
    out_valid_d = out_valid_q;
    out_g_d     = out_g_q;
    out_h_d     = out_h_q;

    unique case (state_q)
      S_LOAD: begin
        if (beat) begin
          for (int i = 0; i < MAT_BITS; i++) begin
            if (bit_cnt_q == BIT_CNT_W'(i)) regs_d[i] = in_bit;
          end
          if (bit_cnt_q == BIT_LAST) begin
            state_d    = S_COMP;
            bit_cnt_d  = '0;
            iter_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      S_COMP: begin
        // Only the vector is rewritten; M stays as loaded.
        regs_d[IDX_E] = mv_g;
        regs_d[IDX_F] = mv_h;
        iter_cnt_d    = iter_cnt_q + CNT_W'(1);
        if (iter_cnt_q == ITER_LAST) begin
          state_d     = S_OUT;
          out_valid_d = 1'b1;
          out_g_d     = mv_g;
          out_h_d     = mv_h;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d     = S_LOAD;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_LOAD;
        out_valid_d = 1'b0;
      end
    endcase

    in_ready_d = (state_d == S_LOAD);
    busy_d     = (state_d != S_LOAD);
  end

  // State and output registers; reset discards any partial load or iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      bit_cnt_q   <= '0;
      iter_cnt_q  <= '0;
      regs_q      <= '0;
      out_valid_q <= 1'b0;
      out_g_q     <= 1'b0;
      out_h_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      iter_cnt_q  <= iter_cnt_d;
      regs_q      <= regs_d;
      out_valid_q <= out_valid_d;
      out_g_q     <= out_g_d;
      out_h_q     <= out_h_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_g     = out_g_q;
  assign out_h     = out_h_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gf2_mat_vec_iter.sv
// Directed bench: two instances (ITERS=1 and ITERS=2) fed the same serial stream.
module tb_gf2_mat_vec_iter;

  logic clk;
  logic rst;
  logic in_valid;
  logic in_bit;
  logic out_ready;

  logic in_ready1, out_valid1, g1, h1, busy1;
  logic in_ready2, out_valid2, g2, h2, busy2;

  int n_checks;
  int n_errors;

  gf2_mat_vec_iter #(.ITERS(1), .CNT_W(4)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .in_bit    (in_bit),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_g     (g1),
    .out_h     (h1),
    .busy      (busy1)
  );

  gf2_mat_vec_iter #(.ITERS(2), .CNT_W(4)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .in_bit    (in_bit),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_g     (g2),
    .out_h     (h2),
    .busy      (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send bits {a,b,c,d,e,f} (a is the MSB), with 'gap' idle cycles before each beat.
  task automatic load6(input logic [5:0] bits, input int gap);
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < gap; k++) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      check_eq("load_ready", 32'({in_ready1, in_ready2}), 32'b11);
      in_valid = 1'b1;
      in_bit   = bits[5-i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  // Edges after the accepting edge until out_valid rises; expected = ITERS.
  task automatic wait_out(input int exp1, input int exp2);
    int lat1;
    int lat2;
    lat1 = -1;
    lat2 = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (out_valid1 && lat1 < 0) lat1 = c;
      if (out_valid2 && lat2 < 0) lat2 = c;
      if (lat1 >= 0 && lat2 >= 0) break;
    end
    check_eq("latency1", 32'(lat1), 32'(exp1));
    check_eq("latency2", 32'(lat2), 32'(exp2));
    check_eq("busy_out", 32'({busy1, busy2}), 32'b11);
  endtask

  task automatic check_res(input string tag, input logic [1:0] exp1, input logic [1:0] exp2);
    check_eq({tag, "_dut1"}, 32'({g1, h1}), 32'(exp1));
    check_eq({tag, "_dut2"}, 32'({g2, h2}), 32'(exp2));
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("post_hs_valid", 32'({out_valid1, out_valid2}), 32'b00);
    check_eq("post_hs_ready", 32'({in_ready1, in_ready2}), 32'b11);
    check_eq("post_hs_busy",  32'({busy1, busy2}), 32'b00);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'({out_valid1, out_valid2}), 32'b00);
    check_eq("rst_gh",    32'({g1, h1, g2, h2}), 32'b0000);
    check_eq("rst_busy",  32'({busy1, busy2}), 32'b00);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rel_ready", 32'({in_ready1, in_ready2}), 32'b11);

    // M=[1 1;0 1], v=(0,1): one step -> (1,1); two steps -> (0,1)
    load6(6'b110101, 0);
    wait_out(1, 2);
    check_res("iter", 2'b11, 2'b01);
    take_out();

    // out_ready high with nothing pending changes nothing
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("idle_ready_valid", 32'({out_valid1, out_valid2}), 32'b00);

    // Identity with two idle cycles between beats
    load6(6'b100110, 2);
    wait_out(1, 2);
    check_res("gaps", 2'b10, 2'b10);
    take_out();

    // Back-pressure with in_valid asserted: nothing captured, outputs stable
    load6(6'b110101, 0);
    wait_out(1, 2);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("bp_valid", 32'({out_valid1, out_valid2}), 32'b11);
      check_eq("bp_ready", 32'({in_ready1, in_ready2}), 32'b00);
      check_res("bp_hold", 2'b11, 2'b01);
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
    take_out();
    load6(6'b100110, 0);
    wait_out(1, 2);
    check_res("after_bp", 2'b10, 2'b10);
    take_out();

    // Reset mid-load after 3 beats, then a fresh full load
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    load6(6'b000011, 0);
    wait_out(1, 2);
    check_res("rst_midload", 2'b00, 2'b00);
    take_out();

    // Reset while in S_OUT clears outputs asynchronously
    load6(6'b110101, 0);
    wait_out(1, 2);
    rst = 1'b1;
    #1;
    check_eq("rst_out_valid", 32'({out_valid1, out_valid2}), 32'b00);
    check_eq("rst_out_gh",    32'({g1, h1, g2, h2}), 32'b0000);
    check_eq("rst_out_busy",  32'({busy1, busy2}), 32'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_out_ready", 32'({in_ready1, in_ready2}), 32'b11);
    load6(6'b100110, 0);
    wait_out(1, 2);
    check_res("after_rst_out", 2'b10, 2'b10);
    take_out();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
